// File: rtl/stats_scan_controller.sv
// stats_scan_controller: scans Count memory words from Base_addr, computes
// unsigned MAX, MIN and floor(AVG), then writes them to Dest_addr..Dest_addr+2.
// Ports:
//   CLK, Reset           clock, asynchronous active-high reset
//   Start                one-cycle request, accepted only while idle
//   Base_addr, Count     operand block start address and length (0..2^ADDR_WIDTH-1)
//   Dest_addr            first of three result addresses
//   Mem_data_rd          memory read data (one cycle after the address)
//   Mem_address          memory address, Mem_data_wr / Mem_write the write port
//   Busy, Done           busy flag, one-cycle completion pulse
//   Max_out/Min_out/Avg_out  results, held until the next run updates them
module stats_scan_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_addr,
    input  logic [ADDR_WIDTH-1:0] Count,
    input  logic [ADDR_WIDTH-1:0] Dest_addr,
    input  logic [DATA_WIDTH-1:0] Mem_data_rd,
    output logic [ADDR_WIDTH-1:0] Mem_address,
    output logic [DATA_WIDTH-1:0] Mem_data_wr,
    output logic                  Mem_write,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Max_out,
    output logic [DATA_WIDTH-1:0] Min_out,
    output logic [DATA_WIDTH-1:0] Avg_out
);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DIV_LAST = ADDR_WIDTH'(2 * DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] WR_LAST  = ADDR_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, DIV, WR, DONE} state_t;
    state_t state, next;

    logic [ADDR_WIDTH-1:0]   base, cnt, dest, idx;
    logic [DATA_WIDTH-1:0]   mx, mn, rem, rem_next;
    logic [2*DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH:0]     sh, diff;
    logic                    vld, first, fits;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !Start ? IDLE : (Count == '0 ? DONE : READ);
            READ:    next = idx == cnt - ONE ? DRAIN : READ;
            DRAIN:   next = DIV;
            DIV:     next = idx == DIV_LAST ? WR : DIV;
            WR:      next = idx == WR_LAST ? DONE : WR;
            default: next = IDLE;
        endcase
    end

    // Restoring division step: the dividend shifts out of sum MSB-first while
    // quotient bits shift in at the LSB, so sum ends up holding the quotient.
    assign sh       = {rem, sum[2*DATA_WIDTH-1]};
    assign diff     = sh - (DATA_WIDTH+1)'(cnt);
    assign fits     = sh >= (DATA_WIDTH+1)'(cnt);
    assign rem_next = fits ? diff[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];

    // Combinational from state so an asynchronous reset drops Mem_write at once.
    assign Busy        = state != IDLE;
    assign Done        = state == DONE;
    assign Mem_write   = state == WR;
    assign Mem_address = state == READ ? base + idx : state == WR ? dest + idx : '0;
    assign Mem_data_wr = state != WR ? '0 : idx == '0 ? Max_out : idx == ONE ? Min_out : Avg_out;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            base    <= '0;
            cnt     <= '0;
            dest    <= '0;
            idx     <= '0;
            mx      <= '0;
            mn      <= '0;
            rem     <= '0;
            sum     <= '0;
            vld     <= 1'b0;
            first   <= 1'b0;
            Max_out <= '0;
            Min_out <= '0;
            Avg_out <= '0;
        end else begin
            state <= next;
            // An address issued in READ returns data one cycle later.
            vld   <= state == READ;
            first <= state == READ && idx == '0;
            if (state == IDLE && Start) begin
                base <= Base_addr;
                cnt  <= Count;
                dest <= Dest_addr;
                idx  <= '0;
                sum  <= '0;
                rem  <= '0;
                if (Count == '0) begin
                    Max_out <= '0;
                    Min_out <= '0;
                    Avg_out <= '0;
                end
            end
            if (state == READ || state == WR)
                idx <= idx + ONE;
            if (state == DRAIN)
                idx <= '0;
            if (state == DIV) begin
                sum <= {sum[2*DATA_WIDTH-2:0], fits};
                rem <= rem_next;
                idx <= next == WR ? '0 : idx + ONE;
                if (next == WR) begin
                    Max_out <= mx;
                    Min_out <= mn;
                    Avg_out <= {sum[DATA_WIDTH-2:0], fits};
                end
            end
            if (vld) begin
                sum <= sum + (2*DATA_WIDTH)'(Mem_data_rd);
                mx  <= first || Mem_data_rd > mx ? Mem_data_rd : mx;
                mn  <= first || Mem_data_rd < mn ? Mem_data_rd : mn;
            end
        end
    end
endmodule
